crc8_frame_checker: RTL and testbench

Receive-side CRC-8 checker for byte-stream frames. It consumes a frame over a valid/ready byte interface and folds every payload byte through the team's registered CRC lookup ROM (`crc_table`). It treats the final byte of the frame (`last_i`) as the transmitted CRC and reports pass/fail plus the computed CRC. It sits directly after the byte deserializer on the receive path, mirroring the generator on the transmit side.

---
 rtl/crc8_pkg.sv | 27 ++
 rtl/crc8_frame_checker_if.sv | 10 +
 rtl/crc_table.sv | 25 ++
 rtl/crc8_frame_checker.sv | 86 ++++++++
 tb/tb_crc8_frame_checker.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/crc8_pkg.sv
// Shared definitions for the receive-side CRC-8 frame checker:
// FSM encoding, CRC/length constants and the lookup-table entry generator.
package crc8_pkg;

    typedef enum logic [1:0] {
        ST_ACCEPT = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam logic [7:0]  CRC_INIT          = 8'h00;
    localparam logic [15:0] LEN_MAX           = 16'hFFFF;
    localparam logic [7:0]  CRC8_POLY_DEFAULT = 8'h07;

    // One table entry: the CRC register after shifting an index byte through
    // eight MSB-first polynomial-division steps (implied x^8 term).
    function automatic logic [7:0] crc8_table_entry(input logic [7:0] index,
                                                    input logic [7:0] poly);
        logic [7:0] c;
        c = index;
        for (int b = 0; b < 8; b++) begin
            c = c[7] ? ((c << 1) ^ poly) : (c << 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/crc8_frame_checker_if.sv
// Byte-stream valid/ready link from the deserializer into the frame checker.
interface crc8_frame_checker_if;
    logic [7:0] data_i;
    logic       valid_i;
    logic       last_i;
    logic       ready_o;

    modport master (output data_i, output valid_i, output last_i, input ready_o);
    modport slave  (input data_i, input valid_i, input last_i, output ready_o);
endinterface

// File: rtl/crc_table.sv
// CRC-8 lookup ROM with a registered read: value_o holds table[addr_i] one
// cycle after addr_i is presented.
module crc_table
    import crc8_pkg::*;
#(
    parameter logic [7:0] POLYNOMIAL = CRC8_POLY_DEFAULT
) (
    input  logic       clk_i,
    input  logic [7:0] addr_i,
    output logic [7:0] value_o
);

    logic [7:0] rom [256];

    generate
        for (genvar gi = 0; gi < 256; gi++) begin : g_rom
            assign rom[gi] = crc8_table_entry(8'(gi), POLYNOMIAL);
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        value_o <= rom[addr_i];
    end

endmodule

// File: rtl/crc8_frame_checker.sv
// Receive-side CRC-8 frame checker: folds payload bytes through the lookup ROM
// and compares the running CRC with the final (CRC) byte of each frame.
module crc8_frame_checker
    import crc8_pkg::*;
#(
    parameter logic [7:0] POLYNOMIAL = CRC8_POLY_DEFAULT
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    crc8_frame_checker_if.slave  bus,
    output logic                 done_o,
    output logic                 crc_ok_o,
    output logic [7:0]           crc_o,
    output logic [15:0]          frame_len_o
);

    state_t      state_reg;
    logic [7:0]  crc_reg;
    logic [15:0] len_reg;
    logic        crc_ok_reg;
    logic [7:0]  crc_out_reg;
    logic [15:0] len_out_reg;

    logic [7:0]  rom_addr;
    logic [7:0]  rom_value;
    logic [15:0] len_next;

    // Address is only meaningful in ACCEPT; the ROM result lands in LOOKUP.
    assign rom_addr = crc_reg ^ bus.data_i;
    assign len_next = (len_reg == LEN_MAX) ? LEN_MAX : len_reg + 16'd1;

    crc_table #(
        .POLYNOMIAL (POLYNOMIAL)
    ) u_crc_table (
        .clk_i   (clk_i),
        .addr_i  (rom_addr),
        .value_o (rom_value)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg   <= ST_ACCEPT;
            crc_reg     <= CRC_INIT;
            len_reg     <= '0;
            crc_ok_reg  <= 1'b0;
            crc_out_reg <= CRC_INIT;
            len_out_reg <= '0;
        end else begin
            case (state_reg)
                ST_ACCEPT: begin
                    if (bus.valid_i) begin
                        len_reg <= len_next;
                        if (bus.last_i) begin
                            crc_ok_reg  <= (crc_reg == bus.data_i);
                            crc_out_reg <= crc_reg;
                            len_out_reg <= len_next;
                            state_reg   <= ST_DONE;
                        end else begin
                            state_reg   <= ST_LOOKUP;
                        end
                    end
                end
                ST_LOOKUP: begin
                    crc_reg   <= rom_value;
                    state_reg <= ST_ACCEPT;
                end
                ST_DONE: begin
                    crc_reg   <= CRC_INIT;
                    len_reg   <= '0;
                    state_reg <= ST_ACCEPT;
                end
                default: begin
                    state_reg <= ST_ACCEPT;
                end
            endcase
        end
    end

    // Handshake and pulse outputs are pure decodes of the state register.
    assign bus.ready_o = (state_reg == ST_ACCEPT);
    assign done_o      = (state_reg == ST_DONE);
    assign crc_ok_o    = crc_ok_reg;
    assign crc_o       = crc_out_reg;
    assign frame_len_o = len_out_reg;

endmodule

// File: tb/tb_crc8_frame_checker.sv
// Scoreboard bench for crc8_frame_checker: the driver queues expected frame
// results, an independent monitor checks them on every done_o pulse.
module tb_crc8_frame_checker;

    typedef struct {
        string       name;
        logic        ok;
        logic [7:0]  crc;
        logic [15:0] len;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        done;
    logic        crc_ok;
    logic [7:0]  crc;
    logic [15:0] frame_len;

    int n_tests = 0;
    int n_fail  = 0;
    int n_done  = 0;
    int n_push  = 0;

    exp_t       sb_q[$];
    logic [7:0] frm[$];

    crc8_frame_checker_if bus();

    crc8_frame_checker #(
        .POLYNOMIAL (8'h07)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .bus         (bus),
        .done_o      (done),
        .crc_ok_o    (crc_ok),
        .crc_o       (crc),
        .frame_len_o (frame_len)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Presents one byte and returns after the edge that transfers it.
    task automatic send_byte(input logic [7:0] d, input logic l, input int gap, output int waits);
        waits = 0;
        repeat (gap) begin
            @(negedge clk);
            bus.valid_i = 1'b0;
        end
        @(negedge clk);
        bus.valid_i = 1'b1;
        bus.data_i  = d;
        bus.last_i  = l;
        while (bus.ready_o !== 1'b1) begin
            @(negedge clk);
            waits++;
            if (waits > 16) begin
                check("handshake_timeout", 32'd0, 32'd1);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int cycles);
        @(negedge clk);
        bus.valid_i = 1'b0;
        bus.last_i  = 1'b0;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic expect_frame(input string name, input logic ok, input logic [7:0] c,
                                input logic [15:0] len);
        exp_t e;
        e.name = name;
        e.ok   = ok;
        e.crc  = c;
        e.len  = len;
        sb_q.push_back(e);
        n_push++;
    endtask

    // Sends frm[] with random gaps of up to max_gap idle cycles; last entry is the CRC byte.
    task automatic send_frame(input int max_gap);
        int w;
        for (int i = 0; i < frm.size(); i++) begin
            send_byte(frm[i], (i == frm.size() - 1), (max_gap > 0) ? $urandom_range(0, max_gap) : 0, w);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_done"},  {31'd0, done},      32'd0);
        check({tag, "_ok"},    {31'd0, crc_ok},    32'd0);
        check({tag, "_crc"},   {24'd0, crc},       32'd0);
        check({tag, "_len"},   {16'd0, frame_len}, 32'd0);
    endtask

    // Monitor: every done_o pulse is matched against the head of the scoreboard.
    logic done_prev = 1'b0;
    always @(negedge clk) begin
        if (!rst && done) begin
            n_done++;
            check("done_single_cycle", {31'd0, done_prev}, 32'd0);
            if (sb_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                $display("[TB] frame %s: ok=%0d crc=0x%02h len=%0d", e.name, crc_ok, crc, frame_len);
                check({e.name, "_ok"},  {31'd0, crc_ok},    {31'd0, e.ok});
                check({e.name, "_crc"}, {24'd0, crc},       {24'd0, e.crc});
                check({e.name, "_len"}, {16'd0, frame_len}, {16'd0, e.len});
            end
        end
        done_prev <= done;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w;
        string s;
        bus.valid_i = 1'b0;
        bus.last_i  = 1'b0;
        bus.data_i  = 8'h00;

        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("reset_ready", {31'd0, bus.ready_o}, 32'd1);

        // {0x01, 0x07} with valid held high: ready 1,0,1,0 from first accept
        expect_frame("ok_0107", 1'b1, 8'h07, 16'd2);
        send_byte(8'h01, 1'b0, 0, w);
        check("t1_wait_b0", w, 32'd0);
        check("t1_ready_after_b0", {31'd0, bus.ready_o}, 32'd0);
        send_byte(8'h07, 1'b1, 0, w);
        check("t1_wait_b1", w, 32'd1);
        check("t1_ready_after_b1", {31'd0, bus.ready_o}, 32'd0);
        check("t1_done_after_b1", {31'd0, done}, 32'd1);
        idle(2);

        frm = '{8'h01, 8'h08};
        expect_frame("bad_0108", 1'b0, 8'h07, 16'd2);
        send_frame(0);
        idle(5);
        check("hold_ok",  {31'd0, crc_ok},    32'd0);
        check("hold_crc", {24'd0, crc},       32'h07);
        check("hold_len", {16'd0, frame_len}, 32'd2);

        s = "123456789";
        frm.delete();
        for (int i = 0; i < s.len(); i++) frm.push_back(s[i]);
        frm.push_back(8'hF4);
        expect_frame("check_str", 1'b1, 8'hF4, 16'd10);
        send_frame(0);
        expect_frame("check_str_gaps", 1'b1, 8'hF4, 16'd10);
        send_frame(3);

        frm = '{8'h00};
        expect_frame("single_00", 1'b1, 8'h00, 16'd1);
        send_frame(0);
        frm = '{8'h5A};
        expect_frame("single_5a", 1'b0, 8'h00, 16'd1);
        send_frame(0);

        // Partial frame to be abandoned by reset; results registers are nonzero beforehand
        frm = '{8'h01, 8'h07};
        expect_frame("pre_rst", 1'b1, 8'h07, 16'd2);
        send_frame(0);
        send_byte(8'h31, 1'b0, 0, w);
        send_byte(8'h32, 1'b0, 0, w);
        send_byte(8'h33, 1'b0, 0, w);
        @(negedge clk);
        bus.valid_i = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_zero_outputs("midrst");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_zero_outputs("postrst");
        check("postrst_ready", {31'd0, bus.ready_o}, 32'd1);
        frm = '{8'h01, 8'h07};
        expect_frame("after_rst", 1'b1, 8'h07, 16'd2);
        send_frame(0);
        idle(2);

        // Long all-zero frame: length counter saturates, CRC stays 0x00
        expect_frame("saturate", 1'b1, 8'h00, 16'hFFFF);
        for (int i = 0; i < 65536; i++) send_byte(8'h00, 1'b0, 0, w);
        send_byte(8'h00, 1'b1, 0, w);
        idle(4);

        check("sb_drained", sb_q.size(), 32'd0);
        check("done_count", n_done, n_push);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
